// File: rtl/vga_pkg.sv
// Shared types and constants for the scaled VGA frame engine.
package vga_pkg;

    // Counter width; totals up to 1024 per axis fit.
    localparam int CNT_W = 10;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } vga_axis_t;

    typedef struct packed {
        vga_axis_t h;
        vga_axis_t v;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480 = '{
        h: '{active: 640, fp: 16, sync: 96, bp: 48},
        v: '{active: 480, fp: 10, sync: 2,  bp: 33}
    };

    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

    localparam int RGB_BPC = 4;
    typedef logic [3*RGB_BPC-1:0] rgb_t;

    // Per-pixel sideband carried down the delay line alongside the ROM read.
    typedef struct packed {
        logic             active;
        logic             hsync;
        logic             vsync;
        logic             in_win;
        logic             frame_start;
        logic [CNT_W-1:0] col;
        logic [CNT_W-1:0] row;
    } vga_side_t;

    function automatic int axis_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters and stage-0 timing flags (sync flags are "asserted", polarity-free).
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic             clk25M,
    input  logic             reset,
    output logic [CNT_W-1:0] h,
    output logic [CNT_W-1:0] v,
    output logic             active,
    output logic             hsync,
    output logic             vsync
);
    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    logic [31:0] h32;
    logic [31:0] v32;

    assign h32 = 32'(h);
    assign v32 = 32'(v);

    // Pixel counter wraps into the line counter, line counter wraps at frame end.
    always_ff @(posedge clk25M) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + CNT_W'(1);
        end else begin
            h <= h + CNT_W'(1);
        end
    end

    assign active = (h32 < H_ACTIVE) && (v32 < V_ACTIVE);
    assign hsync  = (h32 >= H_ACTIVE + H_FP) && (h32 < H_ACTIVE + H_FP + H_SYNC);
    assign vsync  = (v32 >= V_ACTIVE + V_FP) && (v32 < V_ACTIVE + V_FP + V_SYNC);

endmodule

// File: rtl/vga_scaled_frame_engine.sv
// VGA raster engine: timing, scaled-window ROM fetch and latency-aligned pixel output.
module vga_scaled_frame_engine
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = int'(VGA_640x480.h.active),
    parameter int H_FP        = int'(VGA_640x480.h.fp),
    parameter int H_SYNC      = int'(VGA_640x480.h.sync),
    parameter int H_BP        = int'(VGA_640x480.h.bp),
    parameter int V_ACTIVE    = int'(VGA_640x480.v.active),
    parameter int V_FP        = int'(VGA_640x480.v.fp),
    parameter int V_SYNC      = int'(VGA_640x480.v.sync),
    parameter int V_BP        = int'(VGA_640x480.v.bp),
    parameter bit HSYNC_POL   = SYNC_ACTIVE_LOW,
    parameter bit VSYNC_POL   = SYNC_ACTIVE_LOW,
    parameter int BPC         = RGB_BPC,
    parameter int IMG_W       = 64,
    parameter int IMG_H       = 64,
    parameter int SCALE_SHIFT = 2,
    parameter int X0          = 192,
    parameter int Y0          = 112,
    parameter logic [3*BPC-1:0] BORDER_RGB = '0,
    parameter int MEM_LATENCY = 1,
    localparam int ADDR_W     = $clog2(IMG_W * IMG_H)
) (
    input  logic              clk25M,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [3*BPC-1:0]  pix_in,
    output logic [BPC-1:0]    VGA_R,
    output logic [BPC-1:0]    VGA_G,
    output logic [BPC-1:0]    VGA_B,
    output logic              VGA_hsync,
    output logic              VGA_vsync,
    output logic [CNT_W-1:0]  COL_out,
    output logic [CNT_W-1:0]  ROW_out,
    output logic              active_out,
    output logic              frame_start
);
    localparam int LAT     = MEM_LATENCY + 2;
    localparam int WIN_W   = IMG_W << SCALE_SHIFT;
    localparam int WIN_H   = IMG_H << SCALE_SHIFT;
    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (X0 + WIN_W > H_ACTIVE) begin : g_err_win_x
        $error("scaled image window extends past the horizontal active area");
    end
    if (Y0 + WIN_H > V_ACTIVE) begin : g_err_win_y
        $error("scaled image window extends past the vertical active area");
    end
    if (MEM_LATENCY < 1) begin : g_err_lat
        $error("MEM_LATENCY must be at least 1");
    end
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_err_total
        $error("raster totals must fit 10-bit counters");
    end

    logic [CNT_W-1:0]  h;
    logic [CNT_W-1:0]  v;
    logic              s0_active;
    logic              s0_hsync;
    logic              s0_vsync;
    logic [31:0]       h32;
    logic [31:0]       v32;
    logic              in_win;
    logic [CNT_W-1:0]  h_off;
    logic [CNT_W-1:0]  v_off;
    logic [CNT_W-1:0]  tx;
    logic [CNT_W-1:0]  ty;
    logic [ADDR_W-1:0] addr;
    vga_side_t         s0;
    vga_side_t         side_q [1:LAT-1];
    vga_side_t         last;
    logic [3*BPC-1:0]  rgb_next;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk25M (clk25M),
        .reset  (reset),
        .h      (h),
        .v      (v),
        .active (s0_active),
        .hsync  (s0_hsync),
        .vsync  (s0_vsync)
    );

    assign h32    = 32'(h);
    assign v32    = 32'(v);
    assign in_win = (h32 >= X0) && (h32 < X0 + WIN_W) && (v32 >= Y0) && (v32 < Y0 + WIN_H);

    // Offsets are only meaningful inside the window, where they never go negative.
    assign h_off = h - CNT_W'(X0);
    assign v_off = v - CNT_W'(Y0);
    assign tx    = h_off >> SCALE_SHIFT;
    assign ty    = v_off >> SCALE_SHIFT;
    assign addr  = ADDR_W'(ty) * ADDR_W'(IMG_W) + ADDR_W'(tx);

    // Bundle stage-0 sideband for the delay line.
    always_comb begin
        s0             = '0;
        s0.active      = s0_active;
        s0.hsync       = s0_hsync;
        s0.vsync       = s0_vsync;
        s0.in_win      = in_win;
        s0.frame_start = (h == '0) && (v == '0);
        s0.col         = h;
        s0.row         = v;
    end

    // ROM request stage; the address holds outside the window so the ROM bus stays quiet.
    always_ff @(posedge clk25M) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
        end else begin
            mem_rd_en <= in_win;
            if (in_win) begin
                mem_addr <= addr;
            end
        end
    end

    // Sideband delay line; its last stage lines up with valid pix_in.
    always_ff @(posedge clk25M) begin
        if (reset) begin
            for (int k = 1; k < LAT; k++) begin
                side_q[k] <= '0;
            end
        end else begin
            side_q[1] <= s0;
            for (int k = 2; k < LAT; k++) begin
                side_q[k] <= side_q[k-1];
            end
        end
    end

    assign last = side_q[LAT-1];

    // Colour select: blank outside active, border outside window, ROM texel inside.
    always_comb begin
        rgb_next = '0;
        if (last.active) begin
            rgb_next = last.in_win ? pix_in : BORDER_RGB;
        end
    end

    // Output register; every pin leaves here with the same total latency.
    always_ff @(posedge clk25M) begin
        if (reset) begin
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_hsync   <= ~HSYNC_POL;
            VGA_vsync   <= ~VSYNC_POL;
            COL_out     <= '0;
            ROW_out     <= '0;
            active_out  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            VGA_R       <= rgb_next[3*BPC-1 -: BPC];
            VGA_G       <= rgb_next[2*BPC-1 -: BPC];
            VGA_B       <= rgb_next[BPC-1:0];
            VGA_hsync   <= last.hsync ? HSYNC_POL : ~HSYNC_POL;
            VGA_vsync   <= last.vsync ? VSYNC_POL : ~VSYNC_POL;
            COL_out     <= last.col;
            ROW_out     <= last.row;
            active_out  <= last.active;
            frame_start <= last.frame_start;
        end
    end

endmodule

// File: tb/tb_vga_scaled_frame_engine.sv
// Bench: three engine configurations run side by side against a cycle scoreboard
// plus directed checks. Window rows are moved up / vertical timing shrunk so the
// interesting lines are reached in a short run.
module tb_vga_scaled_frame_engine;
    import vga_pkg::*;

    typedef struct packed {
        logic [9:0]  col;
        logic [9:0]  row;
        logic        act;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [11:0] rgb;
    } obs_t;

    // Instance 0: 640x480, latency 1. Instance 1: latency 3, active-high syncs.
    // Instance 2: unscaled image at origin, short 70-line frame.
    localparam int VACT [3] = '{480, 480, 64};
    localparam int VFP  [3] = '{10, 10, 2};
    localparam int VSY  [3] = '{2, 2, 2};
    localparam int VTOT [3] = '{525, 525, 70};
    localparam int X0S  [3] = '{192, 192, 0};
    localparam int Y0S  [3] = '{8, 8, 0};
    localparam int SHS  [3] = '{2, 2, 0};
    localparam int LATS [3] = '{3, 5, 3};
    localparam bit POLS [3] = '{SYNC_ACTIVE_LOW, SYNC_ACTIVE_HIGH, SYNC_ACTIVE_LOW};
    localparam logic [11:0] BRD [3] = '{12'h0F0, 12'h00F, 12'h000};

    logic        clk25M = 1'b0;
    logic        reset  = 1'b1;
    logic [11:0] maddr [3];
    logic        rd    [3];
    logic [11:0] pix   [3];
    logic [3:0]  r     [3];
    logic [3:0]  g     [3];
    logic [3:0]  bl    [3];
    logic        hs    [3];
    logic        vs    [3];
    logic [9:0]  col   [3];
    logic [9:0]  row   [3];
    logic        act   [3];
    logic        fs    [3];
    logic [11:0] rb1, rb2;

    int   n_asserts = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    int   mh   [3];
    int   mv   [3];
    int   held [3];
    obs_t sq   [3][$];
    string nm  [3] = '{"A", "B", "C"};

    always #20 clk25M = ~clk25M;

    vga_scaled_frame_engine #(
        .Y0 (8), .BORDER_RGB (12'h0F0)
    ) dut_a (
        .clk25M (clk25M), .reset (reset), .mem_addr (maddr[0]), .mem_rd_en (rd[0]),
        .pix_in (pix[0]), .VGA_R (r[0]), .VGA_G (g[0]), .VGA_B (bl[0]),
        .VGA_hsync (hs[0]), .VGA_vsync (vs[0]), .COL_out (col[0]), .ROW_out (row[0]),
        .active_out (act[0]), .frame_start (fs[0])
    );

    vga_scaled_frame_engine #(
        .Y0 (8), .BORDER_RGB (12'h00F), .MEM_LATENCY (3),
        .HSYNC_POL (1'b1), .VSYNC_POL (1'b1)
    ) dut_b (
        .clk25M (clk25M), .reset (reset), .mem_addr (maddr[1]), .mem_rd_en (rd[1]),
        .pix_in (pix[1]), .VGA_R (r[1]), .VGA_G (g[1]), .VGA_B (bl[1]),
        .VGA_hsync (hs[1]), .VGA_vsync (vs[1]), .COL_out (col[1]), .ROW_out (row[1]),
        .active_out (act[1]), .frame_start (fs[1])
    );

    vga_scaled_frame_engine #(
        .V_ACTIVE (64), .V_FP (2), .V_SYNC (2), .V_BP (2),
        .SCALE_SHIFT (0), .X0 (0), .Y0 (0)
    ) dut_c (
        .clk25M (clk25M), .reset (reset), .mem_addr (maddr[2]), .mem_rd_en (rd[2]),
        .pix_in (pix[2]), .VGA_R (r[2]), .VGA_G (g[2]), .VGA_B (bl[2]),
        .VGA_hsync (hs[2]), .VGA_vsync (vs[2]), .COL_out (col[2]), .ROW_out (row[2]),
        .active_out (act[2]), .frame_start (fs[2])
    );

    // Address-tagged ROM contents.
    function automatic rgb_t rom(int a);
        rgb_t t;
        t = rgb_t'(a);
        return t ^ 12'hA53;
    endfunction

    // ROM models with 1, 3 and 1 cycles of read latency.
    always @(posedge clk25M) begin
        pix[0] <= rom(int'(maddr[0]));
        rb1    <= rom(int'(maddr[1]));
        rb2    <= rb1;
        pix[1] <= rb2;
        pix[2] <= rom(int'(maddr[2]));
    end

    function automatic bit model_win(int i, int h, int v);
        int sz;
        sz = 64 << SHS[i];
        return (h >= X0S[i]) && (h < X0S[i] + sz) && (v >= Y0S[i]) && (v < Y0S[i] + sz);
    endfunction

    function automatic int model_addr(int i, int h, int v);
        return ((v - Y0S[i]) / (1 << SHS[i])) * 64 + (h - X0S[i]) / (1 << SHS[i]);
    endfunction

    function automatic obs_t model(int i, int h, int v);
        obs_t o;
        bit   a;
        a     = (h < 640) && (v < VACT[i]);
        o     = '0;
        o.col = 10'(h);
        o.row = 10'(v);
        o.act = a;
        o.fs  = (h == 0) && (v == 0);
        o.hs  = (h >= 656 && h < 752) ? POLS[i] : !POLS[i];
        o.vs  = (v >= VACT[i] + VFP[i] && v < VACT[i] + VFP[i] + VSY[i]) ? POLS[i] : !POLS[i];
        if (!a)                       o.rgb = 12'h000;
        else if (!model_win(i, h, v)) o.rgb = BRD[i];
        else                          o.rgb = rom(model_addr(i, h, v));
        return o;
    endfunction

    function automatic obs_t reset_obs(int i);
        obs_t o;
        o    = '0;
        o.hs = !POLS[i];
        o.vs = !POLS[i];
        return o;
    endfunction

    function automatic obs_t get_obs(int i);
        return {col[i], row[i], act[i], hs[i], vs[i], fs[i], r[i], g[i], bl[i]};
    endfunction

    task automatic check(string tag, logic [63:0] observed, logic [63:0] expected);
        n_asserts++;
        assert (observed === expected) else begin
            n_fail++;
            if (n_fail <= 30)
                $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock: advance the reference raster, check ROM request and scoreboard head.
    task automatic step();
        logic rs;
        int   h, v, ea;
        bit   er;
        obs_t e;
        rs = reset;
        @(posedge clk25M);
        #1;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (rs) begin
                held[i] = 0;
                er      = 1'b0;
                ea      = 0;
                sq[i].delete();
                for (int k = 0; k < LATS[i]; k++) sq[i].push_back(reset_obs(i));
                mh[i] = 0;
                mv[i] = 0;
            end else begin
                h = mh[i];
                v = mv[i];
                er = model_win(i, h, v);
                if (er) held[i] = model_addr(i, h, v);
                ea = held[i];
                if (h == 799) begin
                    mh[i] = 0;
                    mv[i] = (v == VTOT[i] - 1) ? 0 : v + 1;
                end else begin
                    mh[i] = h + 1;
                end
            end
            check({nm[i], ".mem_rd_en"}, 64'(rd[i]), 64'(er));
            check({nm[i], ".mem_addr"}, 64'(maddr[i]), 64'(ea));
            e = sq[i].pop_front();
            check({nm[i], ".out"}, 64'(get_obs(i)), 64'(e));
            sq[i].push_back(model(i, mh[i], mv[i]));
        end
    endtask

    task automatic wait_out(int i, int rr, int cc);
        int n;
        n = 0;
        while (!(row[i] == 10'(rr) && col[i] == 10'(cc)) && n < 70000) begin
            step();
            n++;
        end
        check({nm[i], ".reach"}, 64'({row[i], col[i]}), 64'({10'(rr), 10'(cc)}));
    endtask

    initial begin
        int fa, fb, t0, cnt;

        // Reset held for two edges.
        reset = 1'b1;
        step();
        step();
        check("A.rst_rgb", 64'({r[0], g[0], bl[0]}), 64'(0));
        check("A.rst_hsync", 64'(hs[0]), 64'(1));
        check("A.rst_vsync", 64'(vs[0]), 64'(1));
        check("B.rst_hsync", 64'(hs[1]), 64'(0));
        check("A.rst_pos", 64'({row[0], col[0], act[0], fs[0]}), 64'(0));

        // First frame_start after release: LAT edges.
        reset = 1'b0;
        fa = -1; fb = -1; t0 = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (fs[0] === 1'b1 && fa < 0) begin fa = k; t0 = cyc; end
            if (fs[1] === 1'b1 && fb < 0) fb = k;
        end
        check("A.first_fs", 64'(fa), 64'(3));
        check("B.first_fs", 64'(fb), 64'(5));

        // Unscaled window edge on instance C, row 0.
        wait_out(2, 0, 61);
        check("C.addr_63", 64'({rd[2], maddr[2]}), 64'({1'b1, 12'd63}));
        step();
        check("C.addr_held", 64'({rd[2], maddr[2]}), 64'({1'b0, 12'd63}));
        step();
        check("C.rgb_63_0", 64'({r[2], g[2], bl[2]}), 64'(rom(63)));
        step();
        check("C.border_64_0", 64'({act[2], r[2], g[2], bl[2]}), 64'({1'b1, 12'h000}));

        // Horizontal sync on A: low for 96 cycles from column 656.
        wait_out(0, 0, 655);
        check("A.hs_655", 64'(hs[0]), 64'(1));
        step();
        check("A.hs_656", 64'({col[0], hs[0]}), 64'({10'd656, 1'b0}));
        cnt = 1;
        repeat (95) begin
            step();
            if (hs[0] == 1'b0) cnt++;
        end
        check("A.hs_width", 64'(cnt), 64'(96));
        step();
        check("A.hs_752", 64'({col[0], hs[0]}), 64'({10'd752, 1'b1}));

        wait_out(0, 1, 0);
        check("A.line_period", 64'(cyc - t0), 64'(800));

        // Active-high sync on B, same aligned columns.
        wait_out(1, 1, 655);
        check("B.hs_655", 64'(hs[1]), 64'(0));
        step();
        check("B.hs_656", 64'({col[1], hs[1]}), 64'({10'd656, 1'b1}));
        cnt = 1;
        repeat (95) begin
            step();
            if (hs[1] == 1'b1) cnt++;
        end
        check("B.hs_width", 64'(cnt), 64'(96));
        step();
        check("B.hs_752", 64'(hs[1]), 64'(0));

        // Texel replication and border on the window's first row.
        wait_out(0, 8, 191);
        check("A.border_191", 64'({r[0], g[0], bl[0]}), 64'(12'h0F0));
        for (int c = 192; c <= 195; c++) begin
            step();
            check("A.rep_tex0", 64'({col[0], r[0], g[0], bl[0]}), 64'({10'(c), rom(0)}));
        end
        step();
        check("A.tex1_196", 64'({r[0], g[0], bl[0]}), 64'(rom(1)));
        wait_out(0, 8, 448);
        check("A.border_448", 64'({r[0], g[0], bl[0]}), 64'(12'h0F0));
        wait_out(0, 8, 640);
        cnt = 0;
        for (int c = 640; c <= 799; c++) begin
            if (c != 640) step();
            if ({r[0], g[0], bl[0], act[0]} == 13'h0) cnt++;
        end
        check("A.blank_640_799", 64'(cnt), 64'(160));

        // Pixel (232,28): tx=10, ty=5 -> 330.
        wait_out(0, 28, 230);
        check("A.addr_330", 64'({rd[0], maddr[0]}), 64'({1'b1, 12'd330}));
        wait_out(0, 28, 232);
        check("A.rgb_330", 64'({r[0], g[0], bl[0]}), 64'(rom(330)));
        wait_out(1, 28, 232);
        check("B.rgb_330", 64'({r[1], g[1], bl[1]}), 64'(rom(330)));

        // Last texel of the unscaled image.
        wait_out(2, 63, 61);
        check("C.addr_4095", 64'({rd[2], maddr[2]}), 64'({1'b1, 12'd4095}));
        step();
        check("C.addr_4095_held", 64'({rd[2], maddr[2]}), 64'({1'b0, 12'd4095}));
        step();
        check("C.rgb_4095", 64'({r[2], g[2], bl[2]}), 64'(rom(4095)));

        // Vertical sync on C: two whole lines low from row 66.
        wait_out(2, 65, 799);
        check("C.vs_before", 64'(vs[2]), 64'(1));
        step();
        check("C.vs_start", 64'({row[2], col[2], vs[2]}), 64'({10'd66, 10'd0, 1'b0}));
        cnt = 0;
        while (vs[2] == 1'b0 && cnt < 3000) begin
            cnt++;
            step();
        end
        check("C.vs_width", 64'(cnt), 64'(1600));
        check("C.vs_end", 64'({row[2], col[2]}), 64'({10'd68, 10'd0}));

        // Reset mid-hsync: A's counters sit at h=700 on the sampling edge.
        wait_out(0, 69, 697);
        check("A.mid_hsync", 64'(hs[0]), 64'(0));
        reset = 1'b1;
        step();
        check("A.rst2_hsync", 64'(hs[0]), 64'(1));
        check("A.rst2_pos", 64'({row[0], col[0], act[0], fs[0], r[0], g[0], bl[0]}), 64'(0));
        check("A.rst2_mem", 64'({rd[0], maddr[0]}), 64'(0));
        check("B.rst2_hsync", 64'(hs[1]), 64'(0));
        step();
        reset = 1'b0;
        fa = -1; fb = -1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (fs[0] === 1'b1 && fa < 0) fa = k;
            if (fs[1] === 1'b1 && fb < 0) fb = k;
        end
        check("A.fs_after_rst", 64'(fa), 64'(3));
        check("B.fs_after_rst", 64'(fb), 64'(5));
        repeat (20) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
